// File: rtl/cmul_share_arbiter_if.sv
// cmul_share_arbiter_if: requester, multiplier and response bundle
// slave = arbiter side, master = requesters/multiplier/sink side
interface cmul_share_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 21,
  parameter int TWID_WIDTH = 16,
  parameter int ID_W       = $clog2(NUM_REQ),
  parameter int PW         = DATA_WIDTH + TWID_WIDTH + 1
);
  logic                          flush;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_r;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i;
  logic [NUM_REQ*TWID_WIDTH-1:0] req_b_r;
  logic [NUM_REQ*TWID_WIDTH-1:0] req_b_i;
  logic [DATA_WIDTH-1:0]         mul_a_r;
  logic [DATA_WIDTH-1:0]         mul_a_i;
  logic [TWID_WIDTH-1:0]         mul_b_r;
  logic [TWID_WIDTH-1:0]         mul_b_i;
  logic [PW-1:0]                 mul_c_r;
  logic [PW-1:0]                 mul_c_i;
  logic                          resp_valid;
  logic [ID_W-1:0]               resp_id;
  logic [PW-1:0]                 resp_c_r;
  logic [PW-1:0]                 resp_c_i;

  modport slave (
    input  flush, req_valid, req_lock,
    input  req_a_r, req_a_i, req_b_r, req_b_i,
    input  mul_c_r, mul_c_i,
    output req_ready,
    output mul_a_r, mul_a_i, mul_b_r, mul_b_i,
    output resp_valid, resp_id, resp_c_r, resp_c_i
  );

  modport master (
    output flush, req_valid, req_lock,
    output req_a_r, req_a_i, req_b_r, req_b_i,
    output mul_c_r, mul_c_i,
    input  req_ready,
    input  mul_a_r, mul_a_i, mul_b_r, mul_b_i,
    input  resp_valid, resp_id, resp_c_r, resp_c_i
  );
endinterface

// File: rtl/cmul_share_arbiter.sv
// cmul_share_arbiter: round-robin share of one pipelined complex multiplier
// Optional burst lock enabled by defining CMUL_ARB_LOCK_EN
module cmul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 21,
  parameter int TWID_WIDTH  = 16,
  parameter int MUL_LATENCY = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  cmul_share_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TD   = MUL_LATENCY + 1;

  logic [ID_W-1:0]       r_ptr;
  logic [DATA_WIDTH-1:0] r_a_r;
  logic [DATA_WIDTH-1:0] r_a_i;
  logic [TWID_WIDTH-1:0] r_b_r;
  logic [TWID_WIDTH-1:0] r_b_i;
  logic [TD-1:0]         r_tv;
  logic [ID_W-1:0]       r_tid [TD];

  logic               w_hit;
  logic [ID_W-1:0]    w_id;
  logic [ID_W:0]      w_idx;
  logic [ID_W-1:0]    w_next;
  logic [ID_W-1:0]    w_ptr_d;
  logic [NUM_REQ-1:0] w_ready;

`ifdef CMUL_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t          r_state;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] w_own_next;

  assign w_own_next = (r_owner == ID_W'(NUM_REQ - 1)) ?
                      '0 : r_owner + 1'b1;
`else
  logic w_unused_lock;
  assign w_unused_lock = ^bus.req_lock;
`endif

  // first valid requester at or after the pointer, wrapping
  always_comb begin
    w_hit = 1'b0;
    w_id  = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_REQ))
        w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      if (!w_hit && bus.req_valid[w_idx[ID_W-1:0]]) begin
        w_hit = 1'b1;
        w_id  = w_idx[ID_W-1:0];
      end
    end
`ifdef CMUL_ARB_LOCK_EN
    if (r_state == LOCKED) begin
      w_hit = bus.req_valid[r_owner];
      w_id  = r_owner;
    end
`endif
    w_ready = '0;
    if (w_hit && rst_n)
      w_ready[w_id] = 1'b1;
  end

  assign w_next = (w_id == ID_W'(NUM_REQ - 1)) ? '0 : w_id + 1'b1;

  // next pointer: past the winner, or past the owner on a lock release
  always_comb begin
    w_ptr_d = r_ptr;
    if (w_hit)
      w_ptr_d = w_next;
`ifdef CMUL_ARB_LOCK_EN
    if (r_state == LOCKED && bus.flush)
      w_ptr_d = w_own_next;
`endif
  end

  // register winning operands onto the multiplier, zero when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_r <= '0;
      r_a_i <= '0;
      r_b_r <= '0;
      r_b_i <= '0;
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_d;
      if (w_hit) begin
        r_a_r <= bus.req_a_r[w_id*DATA_WIDTH +: DATA_WIDTH];
        r_a_i <= bus.req_a_i[w_id*DATA_WIDTH +: DATA_WIDTH];
        r_b_r <= bus.req_b_r[w_id*TWID_WIDTH +: TWID_WIDTH];
        r_b_i <= bus.req_b_i[w_id*TWID_WIDTH +: TWID_WIDTH];
      end else begin
        r_a_r <= '0;
        r_a_i <= '0;
        r_b_r <= '0;
        r_b_i <= '0;
      end
    end
  end

`ifdef CMUL_ARB_LOCK_EN
  // lock FSM: a locking transfer pins the grant to its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
      r_owner <= '0;
    end else if (bus.flush) begin
      r_state <= ARB;
    end else if (w_hit) begin
      r_state <= bus.req_lock[w_id] ? LOCKED : ARB;
      r_owner <= w_id;
    end
  end
`endif

  // tag pipe: new tag always enters, older tags die on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tv <= '0;
      for (int k = 0; k < TD; k++)
        r_tid[k] <= '0;
    end else begin
      r_tv[0]  <= w_hit;
      r_tid[0] <= w_id;
      for (int k = 1; k < TD; k++) begin
        r_tv[k]  <= r_tv[k-1] & ~bus.flush;
        r_tid[k] <= r_tid[k-1];
      end
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.mul_a_r    = r_a_r;
  assign bus.mul_a_i    = r_a_i;
  assign bus.mul_b_r    = r_b_r;
  assign bus.mul_b_i    = r_b_i;
  assign bus.resp_valid = r_tv[TD-1] & ~bus.flush;
  assign bus.resp_id    = r_tid[TD-1];
  assign bus.resp_c_r   = bus.mul_c_r;
  assign bus.resp_c_i   = bus.mul_c_i;
endmodule
